// File: rtl/scara_pkg.sv
// Shared types for the SCARA inverse-kinematics sequencer.
// Holds the sequencer state enum, the status codes and the angle LSB scale.
package scara_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FK,
        S_CHECK,
        S_SOLVE,
        S_APPLY,
        S_STEP,
        S_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        ST_CONVERGED = 2'd0,
        ST_MAXITER   = 2'd1,
        ST_TIMEOUT   = 2'd2,
        ST_STALL     = 2'd3
    } status_e;

    // Joint angles are kept in 1/16 degree units.
    localparam int ANG_LSB_PER_DEG = 16;

endpackage

// File: rtl/scara_angle_sat.sv
// Combinational saturating signed adder for one joint angle.
// Ports: a, b (signed ANG_W operands) -> sum = clamp(a + b, -LIMIT, +LIMIT).
module scara_angle_sat #(
    parameter int ANG_W = 16,
    parameter int LIMIT = 2880
) (
    input  logic [ANG_W-1:0] a,
    input  logic [ANG_W-1:0] b,
    output logic [ANG_W-1:0] sum
);

    localparam logic signed [ANG_W:0] LIM_P = (ANG_W+1)'(LIMIT);
    localparam logic signed [ANG_W:0] LIM_N = (ANG_W+1)'(-LIMIT);

    // One guard bit: the raw sum of two ANG_W values never wraps.
    logic signed [ANG_W:0] raw;

    always_comb begin
        raw = $signed({a[ANG_W-1], a}) + $signed({b[ANG_W-1], b});
        if (raw > LIM_P) begin
            sum = LIM_P[ANG_W-1:0];
        end else if (raw < LIM_N) begin
            sum = LIM_N[ANG_W-1:0];
        end else begin
            sum = raw[ANG_W-1:0];
        end
    end

endmodule

// File: rtl/scara_ik_sequencer.sv
// Iterative IK sequencer: runs FK -> check -> Jacobian solve -> apply -> step
// until converged, out of iterations, timed out or stalled at a joint limit.
// Ports: cmd_* (move command, valid/ready), fk_* and jac_* (start/done units),
// err_x/err_y (position error), th1/th2 (joint angles), step_* (joint move,
// valid/ready), busy/done/status/iter_count (progress and result).
module scara_ik_sequencer
    import scara_pkg::*;
#(
    parameter int POS_W         = 14,
    parameter int ANG_W         = 16,
    parameter int MAX_ITER      = 8,
    parameter int TOL           = 4,
    parameter int STAGE_TIMEOUT = 1024,
    parameter int TH_LIMIT      = 180 * ANG_LSB_PER_DEG,
    parameter int TH1_INIT      = 45 * ANG_LSB_PER_DEG,
    parameter int TH2_INIT      = 45 * ANG_LSB_PER_DEG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_x,
    input  logic [POS_W-1:0] cmd_y,
    input  logic             cmd_rel,
    output logic             fk_start,
    input  logic             fk_done,
    input  logic [POS_W-1:0] fk_x,
    input  logic [POS_W-1:0] fk_y,
    output logic [POS_W:0]   err_x,
    output logic [POS_W:0]   err_y,
    output logic             jac_start,
    input  logic             jac_done,
    input  logic [ANG_W-1:0] jac_dth1,
    input  logic [ANG_W-1:0] jac_dth2,
    output logic [ANG_W-1:0] th1,
    output logic [ANG_W-1:0] th2,
    output logic             step_valid,
    input  logic             step_ready,
    output logic [ANG_W-1:0] step_dth1,
    output logic [ANG_W-1:0] step_dth2,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [3:0]       iter_count
);

    localparam int WAIT_W = $clog2(STAGE_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STAGE_TIMEOUT - 1);
    localparam logic [3:0] ITER_MAX = 4'(MAX_ITER);
    localparam logic signed [POS_W:0] TOL_P = (POS_W+1)'(TOL);
    localparam logic signed [POS_W:0] TOL_N = (POS_W+1)'(-TOL);
    localparam logic signed [POS_W:0] POS_MAX = (POS_W+1)'((1 << (POS_W-1)) - 1);
    localparam logic signed [POS_W:0] POS_MIN = (POS_W+1)'(-(1 << (POS_W-1)));

    seq_state_e       state_q, state_d;
    status_e          status_q, status_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             fk_start_q, fk_start_d;
    logic             jac_start_q, jac_start_d;
    logic             step_valid_q, step_valid_d;
    logic             done_q, done_d;
    logic             rel_q, rel_d;
    logic             first_q, first_d;
    logic [3:0]       iter_q, iter_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [POS_W-1:0] tgt_x_q, tgt_x_d;
    logic [POS_W-1:0] tgt_y_q, tgt_y_d;
    logic [POS_W:0]   err_x_q, err_x_d;
    logic [POS_W:0]   err_y_q, err_y_d;
    logic [ANG_W-1:0] dth1_q, dth1_d;
    logic [ANG_W-1:0] dth2_q, dth2_d;
    logic [ANG_W-1:0] th1_q, th1_d;
    logic [ANG_W-1:0] th2_q, th2_d;
    logic [ANG_W-1:0] step_dth1_q, step_dth1_d;
    logic [ANG_W-1:0] step_dth2_q, step_dth2_d;

    logic [ANG_W-1:0] th1_new, th2_new;
    logic signed [POS_W:0] fkx_e, fky_e, sum_x, sum_y;
    logic in_tol;

    function automatic logic [POS_W-1:0] sat_pos(input logic signed [POS_W:0] v);
        if (v > POS_MAX) return POS_MAX[POS_W-1:0];
        if (v < POS_MIN) return POS_MIN[POS_W-1:0];
        return v[POS_W-1:0];
    endfunction

    scara_angle_sat #(.ANG_W(ANG_W), .LIMIT(TH_LIMIT)) u_sat1 (
        .a   (th1_q),
        .b   (dth1_q),
        .sum (th1_new)
    );

    scara_angle_sat #(.ANG_W(ANG_W), .LIMIT(TH_LIMIT)) u_sat2 (
        .a   (th2_q),
        .b   (dth2_q),
        .sum (th2_new)
    );

    // tgt_*_q holds the raw command until the first FK result of a relative
    // move turns it into an absolute target.
    assign fkx_e = $signed({fk_x[POS_W-1], fk_x});
    assign fky_e = $signed({fk_y[POS_W-1], fk_y});
    assign sum_x = fkx_e + $signed({tgt_x_q[POS_W-1], tgt_x_q});
    assign sum_y = fky_e + $signed({tgt_y_q[POS_W-1], tgt_y_q});

    assign in_tol = ($signed(err_x_q) <= TOL_P) && ($signed(err_x_q) >= TOL_N) &&
                    ($signed(err_y_q) <= TOL_P) && ($signed(err_y_q) >= TOL_N);

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        cmd_ready_d = cmd_ready_q;
        fk_start_d  = 1'b0;
        jac_start_d = 1'b0;
        done_d      = 1'b0;
        step_valid_d = step_valid_q;
        rel_d       = rel_q;
        first_d     = first_q;
        iter_d      = iter_q;
        wait_d      = wait_q;
        tgt_x_d     = tgt_x_q;
        tgt_y_d     = tgt_y_q;
        err_x_d     = err_x_q;
        err_y_d     = err_y_q;
        dth1_d      = dth1_q;
        dth2_d      = dth2_q;
        th1_d       = th1_q;
        th2_d       = th2_q;
        step_dth1_d = step_dth1_q;
        step_dth2_d = step_dth2_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    tgt_x_d     = cmd_x;
                    tgt_y_d     = cmd_y;
                    rel_d       = cmd_rel;
                    first_d     = 1'b1;
                    iter_d      = 4'd0;
                    status_d    = ST_CONVERGED;
                    cmd_ready_d = 1'b0;
                    fk_start_d  = 1'b1;
                    wait_d      = '0;
                    state_d     = S_FK;
                end
            end
            S_FK: begin
                if (fk_done) begin
                    if (first_q && rel_q) begin
                        tgt_x_d = sat_pos(sum_x);
                        tgt_y_d = sat_pos(sum_y);
                    end
                    first_d = 1'b0;
                    err_x_d = $signed({tgt_x_d[POS_W-1], tgt_x_d}) - fkx_e;
                    err_y_d = $signed({tgt_y_d[POS_W-1], tgt_y_d}) - fky_e;
                    state_d = S_CHECK;
                end else if (wait_q == WAIT_LAST) begin
                    status_d = ST_TIMEOUT;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (in_tol) begin
                    status_d = ST_CONVERGED;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (iter_q == ITER_MAX) begin
                    status_d = ST_MAXITER;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    jac_start_d = 1'b1;
                    wait_d      = '0;
                    state_d     = S_SOLVE;
                end
            end
            S_SOLVE: begin
                if (jac_done) begin
                    dth1_d  = jac_dth1;
                    dth2_d  = jac_dth2;
                    state_d = S_APPLY;
                end else if (wait_q == WAIT_LAST) begin
                    status_d = ST_TIMEOUT;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_APPLY: begin
                th1_d       = th1_new;
                th2_d       = th2_new;
                step_dth1_d = th1_new - th1_q;
                step_dth2_d = th2_new - th2_q;
                // Error is known to exceed TOL here, so no motion means stuck.
                if (th1_new == th1_q && th2_new == th2_q) begin
                    status_d = ST_STALL;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    step_valid_d = 1'b1;
                    wait_d       = '0;
                    state_d      = S_STEP;
                end
            end
            S_STEP: begin
                if (step_valid_q && step_ready) begin
                    step_valid_d = 1'b0;
                    iter_d       = iter_q + 4'd1;
                    fk_start_d   = 1'b1;
                    wait_d       = '0;
                    state_d      = S_FK;
                end else if (wait_q == WAIT_LAST) begin
                    step_valid_d = 1'b0;
                    status_d     = ST_TIMEOUT;
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            status_q     <= ST_CONVERGED;
            cmd_ready_q  <= 1'b1;
            fk_start_q   <= 1'b0;
            jac_start_q  <= 1'b0;
            step_valid_q <= 1'b0;
            done_q       <= 1'b0;
            rel_q        <= 1'b0;
            first_q      <= 1'b0;
            iter_q       <= 4'd0;
            wait_q       <= '0;
            tgt_x_q      <= '0;
            tgt_y_q      <= '0;
            err_x_q      <= '0;
            err_y_q      <= '0;
            dth1_q       <= '0;
            dth2_q       <= '0;
            th1_q        <= ANG_W'(TH1_INIT);
            th2_q        <= ANG_W'(TH2_INIT);
            step_dth1_q  <= '0;
            step_dth2_q  <= '0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            cmd_ready_q  <= cmd_ready_d;
            fk_start_q   <= fk_start_d;
            jac_start_q  <= jac_start_d;
            step_valid_q <= step_valid_d;
            done_q       <= done_d;
            rel_q        <= rel_d;
            first_q      <= first_d;
            iter_q       <= iter_d;
            wait_q       <= wait_d;
            tgt_x_q      <= tgt_x_d;
            tgt_y_q      <= tgt_y_d;
            err_x_q      <= err_x_d;
            err_y_q      <= err_y_d;
            dth1_q       <= dth1_d;
            dth2_q       <= dth2_d;
            th1_q        <= th1_d;
            th2_q        <= th2_d;
            step_dth1_q  <= step_dth1_d;
            step_dth2_q  <= step_dth2_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign fk_start   = fk_start_q;
    assign jac_start  = jac_start_q;
    assign step_valid = step_valid_q;
    assign done       = done_q;
    assign busy       = (state_q != S_IDLE);
    assign status     = status_q;
    assign iter_count = iter_q;
    assign err_x      = err_x_q;
    assign err_y      = err_y_q;
    assign th1        = th1_q;
    assign th2        = th2_q;
    assign step_dth1  = step_dth1_q;
    assign step_dth2  = step_dth2_q;

endmodule

// File: tb/tb_scara_ik_sequencer.sv
// Scoreboard bench for scara_ik_sequencer: scripted FK/Jacobian responders,
// a behavioural iteration model, and a monitor comparing every DUT event.
module tb_scara_ik_sequencer;

    localparam int POS_W    = 14;
    localparam int ANG_W    = 16;
    localparam int MAX_ITER = 3;
    localparam int TOL      = 4;
    localparam int TOUT     = 16;
    localparam int LIM      = 2880;
    localparam int PMAX     = 8191;
    localparam int PMIN     = -8192;

    typedef struct { int ex; int ey; } err_t;
    typedef struct { int d1; int d2; int th1; int th2; } step_t;
    typedef struct { int st; int it; int th1; int th2; bit run; } done_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [POS_W-1:0] cmd_x, cmd_y;
    logic             cmd_rel;
    logic             fk_start, fk_done;
    logic [POS_W-1:0] fk_x, fk_y;
    logic [POS_W:0]   err_x, err_y;
    logic             jac_start, jac_done;
    logic [ANG_W-1:0] jac_dth1, jac_dth2;
    logic [ANG_W-1:0] th1, th2;
    logic             step_valid, step_ready;
    logic [ANG_W-1:0] step_dth1, step_dth2;
    logic             busy, done;
    logic [1:0]       status;
    logic [3:0]       iter_count;

    always #5 clk = ~clk;

    scara_ik_sequencer #(
        .MAX_ITER      (MAX_ITER),
        .STAGE_TIMEOUT (TOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_rel    (cmd_rel),
        .fk_start   (fk_start),
        .fk_done    (fk_done),
        .fk_x       (fk_x),
        .fk_y       (fk_y),
        .err_x      (err_x),
        .err_y      (err_y),
        .jac_start  (jac_start),
        .jac_done   (jac_done),
        .jac_dth1   (jac_dth1),
        .jac_dth2   (jac_dth2),
        .th1        (th1),
        .th2        (th2),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_dth1  (step_dth1),
        .step_dth2  (step_dth2),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .iter_count (iter_count)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int sv_run = 0;
    int m_th1 = 720;
    int m_th2 = 720;
    bit stall_step = 1'b0;
    bit jac_hold = 1'b0;
    int fk_xs[$], fk_ys[$], j1s[$], j2s[$];
    err_t  err_q[$];
    step_t step_q[$];
    done_t done_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rnd(input int r);
        return int'($urandom_range(0, 2 * r)) - r;
    endfunction

    task automatic clr();
        fk_xs.delete(); fk_ys.delete(); j1s.delete(); j2s.delete();
    endtask

    task automatic add_fk(input int x, input int y);
        fk_xs.push_back(x); fk_ys.push_back(y);
    endtask

    task automatic add_jac(input int a, input int b);
        j1s.push_back(a); j2s.push_back(b);
    endtask

    // Walks the solve loop on the scripted world and records every event
    // the sequencer should produce for this command.
    task automatic model(input int cx, input int cy, input bit rel, input bit stall);
        int tx, ty, ex, ey, n1, n2, a1, a2, it;
        bit fin;
        tx = cx; ty = cy; it = 0; fin = 1'b0;
        for (int i = 0; i < fk_xs.size() && !fin; i++) begin
            if (i == 0 && rel) begin
                tx = clampi(fk_xs[0] + cx, PMIN, PMAX);
                ty = clampi(fk_ys[0] + cy, PMIN, PMAX);
            end
            ex = tx - fk_xs[i];
            ey = ty - fk_ys[i];
            if (absi(ex) <= TOL && absi(ey) <= TOL) begin
                done_q.push_back('{0, it, m_th1, m_th2, 1'b0});
                fin = 1'b1;
            end else if (it == MAX_ITER) begin
                done_q.push_back('{1, it, m_th1, m_th2, 1'b0});
                fin = 1'b1;
            end else begin
                err_q.push_back('{ex, ey});
                n1 = clampi(m_th1 + j1s[i], -LIM, LIM);
                n2 = clampi(m_th2 + j2s[i], -LIM, LIM);
                a1 = n1 - m_th1;
                a2 = n2 - m_th2;
                m_th1 = n1;
                m_th2 = n2;
                if (a1 == 0 && a2 == 0) begin
                    done_q.push_back('{3, it, m_th1, m_th2, 1'b0});
                    fin = 1'b1;
                end else if (stall) begin
                    done_q.push_back('{2, it, m_th1, m_th2, 1'b1});
                    fin = 1'b1;
                end else begin
                    step_q.push_back('{a1, a2, m_th1, m_th2});
                    it++;
                end
            end
        end
    endtask

    task automatic issue(input int cx, input int cy, input bit rel);
        for (int k = 0; k < 50 && !cmd_ready; k++) begin
            @(posedge clk); #1;
        end
        cmd_x = POS_W'(cx);
        cmd_y = POS_W'(cy);
        cmd_rel = rel;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input int cx, input int cy, input bit rel, input bit stall);
        int start;
        model(cx, cy, rel, stall);
        stall_step = stall;
        issue(cx, cy, rel);
        start = done_cnt;
        for (int k = 0; k < 2000 && done_cnt == start; k++) @(posedge clk);
        chk("done_in_time", int'(done_cnt != start), 1);
        #1;
        stall_step = 1'b0;
        if (done_cnt == start) begin
            err_q.delete(); step_q.delete(); done_q.delete();
        end
    endtask

    // FK unit: answers 3 cycles after fk_start with the next scripted pose.
    initial begin
        fk_done = 1'b0; fk_x = '0; fk_y = '0;
        forever begin
            @(negedge clk);
            if (!reset && fk_start && fk_xs.size() > 0) begin
                int vx, vy;
                vx = fk_xs.pop_front();
                vy = fk_ys.pop_front();
                repeat (3) @(posedge clk);
                #1;
                fk_x = POS_W'(vx);
                fk_y = POS_W'(vy);
                fk_done = 1'b1;
                @(posedge clk); #1;
                fk_done = 1'b0;
            end
        end
    end

    // Jacobian unit: answers after a random 1..4 cycles.
    initial begin
        jac_done = 1'b0; jac_dth1 = '0; jac_dth2 = '0;
        forever begin
            @(negedge clk);
            if (!reset && jac_start && !jac_hold && j1s.size() > 0) begin
                int d1, d2;
                d1 = j1s.pop_front();
                d2 = j2s.pop_front();
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                jac_dth1 = ANG_W'(d1);
                jac_dth2 = ANG_W'(d2);
                jac_done = 1'b1;
                @(posedge clk); #1;
                jac_done = 1'b0;
            end
        end
    end

    initial begin
        step_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            step_ready = stall_step ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) begin
        err_t e;
        step_t s;
        done_t d;
        if (!reset) begin
            if (fk_start) sv_run = 0;
            else if (step_valid && !step_ready) sv_run++;
            if (jac_start) begin
                chk("jac_start_expected", int'(err_q.size() > 0), 1);
                if (err_q.size() > 0) begin
                    e = err_q.pop_front();
                    chk("err_x", int'($signed(err_x)), e.ex);
                    chk("err_y", int'($signed(err_y)), e.ey);
                end
            end
            if (step_valid && step_ready) begin
                chk("step_expected", int'(step_q.size() > 0), 1);
                if (step_q.size() > 0) begin
                    s = step_q.pop_front();
                    chk("step_dth1", int'($signed(step_dth1)), s.d1);
                    chk("step_dth2", int'($signed(step_dth2)), s.d2);
                    chk("step_th1", int'($signed(th1)), s.th1);
                    chk("step_th2", int'($signed(th2)), s.th2);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_expected", int'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    d = done_q.pop_front();
                    chk("status", int'(status), d.st);
                    chk("iter_count", int'(iter_count), d.it);
                    chk("done_th1", int'($signed(th1)), d.th1);
                    chk("done_th2", int'($signed(th2)), d.th2);
                    chk("done_step_valid", int'(step_valid), 0);
                    if (d.run) chk("timeout_wait", sv_run, TOUT);
                end
                chk("steps_left", step_q.size(), 0);
                chk("errs_left", err_q.size(), 0);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cx, cy, tx, ty, fx0, fy0;
        bit rel;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_rel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_th1", int'($signed(th1)), 720);
        chk("rst_th2", int'($signed(th2)), 720);
        chk("rst_status", int'(status), 0);
        chk("rst_iter", int'(iter_count), 0);
        chk("rst_strobes", int'({fk_start, jac_start, step_valid, done}), 0);
        chk("rst_err", int'({err_x, err_y}), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Already within tolerance on the first FK: no solve, no step.
        clr(); add_fk(100, 52);
        run_cmd(100, 50, 1'b0, 1'b0);

        // Relative move: target is first FK pose plus offset.
        clr(); add_fk(60, 60); add_fk(79, 60); add_jac(40, 0);
        run_cmd(20, 0, 1'b1, 1'b0);

        // Never converges: exhausts all iterations.
        clr();
        for (int i = 0; i <= MAX_ITER; i++) add_fk(0, 0);
        for (int i = 0; i < MAX_ITER; i++) add_jac(1, 1);
        run_cmd(500, 500, 1'b0, 1'b0);

        // Drive th1 to 2870, then clip at +2880, then stall.
        clr();
        for (int i = 0; i < 3; i++) add_fk(0, 0);
        add_jac(2870 - m_th1, 0); add_jac(40, 0); add_jac(40, 0);
        run_cmd(1000, 0, 1'b0, 1'b0);
        chk("th1_at_limit", int'($signed(th1)), 2880);

        // Stepper never ready: stage timeout after APPLY.
        clr(); add_fk(500, 500); add_jac(-100, 50);
        run_cmd(0, 0, 1'b0, 1'b1);

        // Relative target saturates to the position range.
        clr(); add_fk(8000, -8000); add_fk(8190, -8190); add_jac(10, 10);
        run_cmd(500, -500, 1'b1, 1'b0);

        // Reset while waiting in SOLVE.
        clr(); add_fk(0, 0); add_jac(5, 5);
        jac_hold = 1'b1;
        err_q.push_back('{1000, 1000});
        issue(1000, 1000, 1'b0);
        for (int k = 0; k < 100 && !jac_start; k++) @(negedge clk);
        chk("solve_reached", int'(jac_start), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        chk("abort_th1", int'($signed(th1)), 720);
        chk("abort_th2", int'($signed(th2)), 720);
        chk("abort_done", int'(done), 0);
        m_th1 = 720;
        m_th2 = 720;
        repeat (20) @(posedge clk);
        #1;
        jac_hold = 1'b0;

        for (int n = 0; n < 40; n++) begin
            rel = 1'($urandom_range(0, 1));
            clr();
            fx0 = rnd(3000);
            fy0 = rnd(3000);
            cx = rel ? rnd(600) : rnd(3000);
            cy = rel ? rnd(600) : rnd(3000);
            tx = rel ? clampi(fx0 + cx, PMIN, PMAX) : cx;
            ty = rel ? clampi(fy0 + cy, PMIN, PMAX) : cy;
            add_fk(fx0, fy0);
            for (int i = 1; i <= MAX_ITER; i++) begin
                if ($urandom_range(0, 3) == 0)
                    add_fk(clampi(tx + rnd(5), PMIN, PMAX), clampi(ty + rnd(5), PMIN, PMAX));
                else
                    add_fk(clampi(tx + rnd(300), PMIN, PMAX), clampi(ty + rnd(300), PMIN, PMAX));
            end
            for (int i = 0; i < MAX_ITER; i++) begin
                if ($urandom_range(0, 7) == 0) add_jac(0, 0);
                else add_jac(rnd(1500), rnd(1500));
            end
            run_cmd(cx, cy, rel, $urandom_range(0, 7) == 0);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
